// File: rtl/ucsbece154a_rf_wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Defining RF_WB_BYPASS_EN adds a same-cycle bypass of port-B results to the decode stage.
package ucsbece154a_rf_wb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    BUBBLE = 2'd2,
    GRANT  = 2'd3
  } arb_state_t;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         STARVE_MAX_DEF = 4;

endpackage

// File: rtl/ucsbece154a_rf_scoreboard.sv
// Pending-write scoreboard for registers owned by the long-latency port.
// It also provides the source-hazard and write-after-write lookups.
module ucsbece154a_rf_scoreboard
  import ucsbece154a_rf_wb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n_i,
  input  logic        set_en,
  input  logic [4:0]  set_idx,
  input  logic        clr_en,
  input  logic [4:0]  clr_idx,
  input  logic [4:0]  a1,
  input  logic [4:0]  a2,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        hz1,
  output logic        hz2,
  output logic        waw,
  output logic [31:0] pending
);

  logic [31:0] pending_r;
  logic [31:0] pending_nxt_s;

  // Next pending vector: the clear is applied first so a same-index set wins.
  always_comb begin
    pending_nxt_s = pending_r;
    if (clr_en) begin
      pending_nxt_s[clr_idx] = 1'b0;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
    if (set_en && (set_idx != REG_ZERO)) begin
      pending_nxt_s[set_idx] = 1'b1;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
    pending_nxt_s[0] = 1'b0;
  end

  // Pending vector register.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pending_r <= 32'd0;
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  assign hz1     = (a1 != REG_ZERO) & pending_r[a1];
  assign hz2     = (a2 != REG_ZERO) & pending_r[a2];
  assign waw     = issue_valid & pending_r[issue_rd];
  assign pending = pending_r;

endmodule

// File: rtl/ucsbece154a_rf_wb_arbiter.sv
// Arbitrates the RF write port between pipeline writeback (A) and a long-latency unit (B).
// Defining RF_WB_BYPASS_EN adds byp1_o/byp2_o/byp_wd_o for same-cycle forwarding of B results.
module ucsbece154a_rf_wb_arbiter
  import ucsbece154a_rf_wb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        rst_n_i,
  input  logic        a_we_i,
  input  logic [4:0]  a_rd_i,
  input  logic [31:0] a_wd_i,
  input  logic        b_valid_i,
  input  logic [4:0]  b_rd_i,
  input  logic [31:0] b_wd_i,
  output logic        b_ready_o,
  input  logic        issue_valid_i,
  input  logic [4:0]  issue_rd_i,
  input  logic [4:0]  a1_i,
  input  logic [4:0]  a2_i,
  output logic        hz1_o,
  output logic        hz2_o,
  output logic        waw_o,
  output logic        stall_o,
  output logic        we3_o,
  output logic [4:0]  a3_o,
  output logic [31:0] wd3_o
`ifdef RF_WB_BYPASS_EN
  ,
  output logic        byp1_o,
  output logic        byp2_o,
  output logic [31:0] byp_wd_o
`endif
);

  arb_state_t       state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             stall_r;
  logic             b_ready_s;
  logic             sb_hz1_s, sb_hz2_s;
  logic [31:0]      pending_s;

  assign b_ready_s = b_valid_i & ~a_we_i;
  assign b_ready_o = b_ready_s;
  assign we3_o     = a_we_i | b_ready_s;
  assign stall_o   = stall_r;

  // Write-port mux: A has priority, outputs are zero when nobody writes.
  always_comb begin
    a3_o  = 5'd0;
    wd3_o = 32'd0;
    if (a_we_i) begin
      a3_o  = a_rd_i;
      wd3_o = a_wd_i;
    end else if (b_ready_s) begin
      a3_o  = b_rd_i;
      wd3_o = b_wd_i;
    end else begin
      a3_o  = 5'd0;
      wd3_o = 32'd0;
    end
  end

  ucsbece154a_rf_scoreboard u_sb (
    .clk         (clk),
    .rst_n_i     (rst_n_i),
    .set_en      (issue_valid_i),
    .set_idx     (issue_rd_i),
    .clr_en      (b_ready_s),
    .clr_idx     (b_rd_i),
    .a1          (a1_i),
    .a2          (a2_i),
    .issue_valid (issue_valid_i),
    .issue_rd    (issue_rd_i),
    .hz1         (sb_hz1_s),
    .hz2         (sb_hz2_s),
    .waw         (waw_o),
    .pending     (pending_s)
  );

`ifdef RF_WB_BYPASS_EN
  assign byp1_o   = b_ready_s & (b_rd_i == a1_i) & (a1_i != REG_ZERO);
  assign byp2_o   = b_ready_s & (b_rd_i == a2_i) & (a2_i != REG_ZERO);
  assign byp_wd_o = b_ready_s ? b_wd_i : 32'd0;
  assign hz1_o    = sb_hz1_s & ~byp1_o;
  assign hz2_o    = sb_hz2_s & ~byp2_o;
`else
  assign hz1_o    = sb_hz1_s;
  assign hz2_o    = sb_hz2_s;
`endif

  // Starvation FSM next state: count consecutive refusals of a waiting B result.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (b_valid_i && a_we_i) begin
          cnt_nxt_s   = cnt_r + CNT_W'(1);
          state_nxt_s = WAIT;
        end else begin
          cnt_nxt_s   = CNT_W'(0);
        end
      end
      WAIT: begin
        if (b_ready_s || !b_valid_i) begin
          cnt_nxt_s   = CNT_W'(0);
          state_nxt_s = IDLE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
          if (cnt_nxt_s == CNT_W'(STARVE_MAX - 1)) begin
            state_nxt_s = BUBBLE;
          end else begin
            state_nxt_s = WAIT;
          end
        end
      end
      BUBBLE: begin
        state_nxt_s = GRANT;
      end
      GRANT: begin
        cnt_nxt_s   = CNT_W'(0);
        state_nxt_s = IDLE;
      end
      default: begin
        cnt_nxt_s   = CNT_W'(0);
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state, counter and registered bubble request (high only while in BUBBLE).
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= IDLE;
      cnt_r   <= CNT_W'(0);
      stall_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      stall_r <= (state_nxt_s == BUBBLE);
    end
  end

`ifndef SYNTHESIS
  logic grant_err_r;

  // Sticky flag: pipeline wrote in the cycle it promised to leave free.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      grant_err_r <= 1'b0;
    end else begin
      grant_err_r <= grant_err_r | ((state_r == GRANT) & a_we_i);
    end
  end
`endif

endmodule

// File: tb/tb_ucsbece154a_rf_wb_arbiter.sv
// Directed bench for the RF writeback arbiter (default build, STARVE_MAX=4).
module tb_ucsbece154a_rf_wb_arbiter;
  import ucsbece154a_rf_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        a_we_i, b_valid_i, issue_valid_i;
  logic [4:0]  a_rd_i, b_rd_i, issue_rd_i, a1_i, a2_i;
  logic [31:0] a_wd_i, b_wd_i;
  logic        b_ready_o, hz1_o, hz2_o, waw_o, stall_o, we3_o;
  logic [4:0]  a3_o;
  logic [31:0] wd3_o;
`ifdef RF_WB_BYPASS_EN
  logic        byp1_o, byp2_o;
  logic [31:0] byp_wd_o;
`endif

  int total = 0;
  int bad   = 0;

  ucsbece154a_rf_wb_arbiter #(.STARVE_MAX(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n_i(rst_n_i),
    .a_we_i(a_we_i), .a_rd_i(a_rd_i), .a_wd_i(a_wd_i),
    .b_valid_i(b_valid_i), .b_rd_i(b_rd_i), .b_wd_i(b_wd_i), .b_ready_o(b_ready_o),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
    .a1_i(a1_i), .a2_i(a2_i), .hz1_o(hz1_o), .hz2_o(hz2_o), .waw_o(waw_o),
    .stall_o(stall_o), .we3_o(we3_o), .a3_o(a3_o), .wd3_o(wd3_o)
`ifdef RF_WB_BYPASS_EN
    , .byp1_o(byp1_o), .byp2_o(byp2_o), .byp_wd_o(byp_wd_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n_i = 1'b0;
    a_we_i = 1'b0; a_rd_i = 5'd0; a_wd_i = 32'd0;
    b_valid_i = 1'b0; b_rd_i = 5'd0; b_wd_i = 32'd0;
    issue_valid_i = 1'b0; issue_rd_i = 5'd0;
    a1_i = 5'd5; a2_i = 5'd0;
    #3;
    chk("rst_we3", 32'(we3_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_pending", dut.u_sb.pending, 32'd0);
    chk("rst_hz1", 32'(hz1_o), 32'd0);
    chk("rst_hz2", 32'(hz2_o), 32'd0);
    chk("rst_bready", 32'(b_ready_o), 32'd0);
    @(negedge clk);
    rst_n_i = 1'b1;
    tick();
    chk("idle_we3", 32'(we3_o), 32'd0);
    chk("idle_a3", 32'(a3_o), 32'd0);

    // Issue rd=7, then look it up.
    issue_valid_i = 1'b1; issue_rd_i = 5'd7;
    #1 chk("issue7_waw", 32'(waw_o), 32'd0);
    tick();
    issue_valid_i = 1'b0; a1_i = 5'd7;
    #1;
    chk("hz1_rd7", 32'(hz1_o), 32'd1);
    chk("pend_rd7", dut.u_sb.pending, 32'h0000_0080);

    // B completes rd=7 while A idle.
    b_valid_i = 1'b1; b_rd_i = 5'd7; b_wd_i = 32'hDEAD_BEEF;
    #1;
    chk("b7_ready", 32'(b_ready_o), 32'd1);
    chk("b7_we3", 32'(we3_o), 32'd1);
    chk("b7_a3", 32'(a3_o), 32'd7);
    chk("b7_wd3", wd3_o, 32'hDEAD_BEEF);
`ifdef RF_WB_BYPASS_EN
    chk("b7_hz1_cycle", 32'(hz1_o), 32'd0);
`else
    chk("b7_hz1_cycle", 32'(hz1_o), 32'd1);
`endif
    tick();
    b_valid_i = 1'b0;
    #1;
    chk("b7_hz1_after", 32'(hz1_o), 32'd0);
    chk("b7_we3_after", 32'(we3_o), 32'd0);
    chk("b7_wd3_after", wd3_o, 32'd0);

    // A-only write.
    a_we_i = 1'b1; a_rd_i = 5'd12; a_wd_i = 32'h0000_1234;
    #1;
    chk("a12_a3", 32'(a3_o), 32'd12);
    chk("a12_wd3", wd3_o, 32'h0000_1234);
    chk("a12_bready", 32'(b_ready_o), 32'd0);
    tick();

    // Starvation: A and B collide.
    a_rd_i = 5'd1; b_valid_i = 1'b1; b_rd_i = 5'd4; b_wd_i = 32'h0000_CAFE;
    #1;
    chk("st_c1_bready", 32'(b_ready_o), 32'd0);
    chk("st_c1_a3", 32'(a3_o), 32'd1);
    tick();
    chk("st_c2_bready", 32'(b_ready_o), 32'd0);
    chk("st_c2_stall", 32'(stall_o), 32'd0);
    chk("st_c2_cnt", 32'(dut.cnt_r), 32'd1);
    tick();
    chk("st_c3_stall", 32'(stall_o), 32'd0);
    chk("st_c3_cnt", 32'(dut.cnt_r), 32'd2);
    tick();
    chk("st_c4_stall", 32'(stall_o), 32'd1);
    chk("st_c4_bready", 32'(b_ready_o), 32'd0);
    chk("st_c4_state", 32'(dut.state_r), 32'(BUBBLE));
    tick();
    a_we_i = 1'b0;
    #1;
    chk("st_c5_stall", 32'(stall_o), 32'd0);
    chk("st_c5_bready", 32'(b_ready_o), 32'd1);
    chk("st_c5_a3", 32'(a3_o), 32'd4);
    chk("st_c5_wd3", wd3_o, 32'h0000_CAFE);
    tick();
    b_valid_i = 1'b0;
    #1;
    chk("st_end_cnt", 32'(dut.cnt_r), 32'd0);
    chk("st_end_state", 32'(dut.state_r), 32'(IDLE));

    // Same-edge set and clear of rd=9: set wins.
    issue_valid_i = 1'b1; issue_rd_i = 5'd9;
    b_valid_i = 1'b1; b_rd_i = 5'd9; b_wd_i = 32'h0000_0009;
    #1 chk("sc9_bready", 32'(b_ready_o), 32'd1);
    tick();
    b_valid_i = 1'b0;
    #1;
    chk("sc9_pending", dut.u_sb.pending, 32'h0000_0200);
    chk("sc9_waw", 32'(waw_o), 32'd1);
    tick();
    issue_valid_i = 1'b0;
    #1 chk("sc9_sticky", dut.u_sb.pending, 32'h0000_0200);

    // x0: pass-through write, never pending.
    issue_valid_i = 1'b1; issue_rd_i = 5'd0;
    a_we_i = 1'b1; a_rd_i = 5'd0; a_wd_i = 32'h0000_0005;
    a1_i = 5'd0; a2_i = 5'd0;
    #1;
    chk("x0_we3", 32'(we3_o), 32'd1);
    chk("x0_a3", 32'(a3_o), 32'd0);
    chk("x0_wd3", wd3_o, 32'h0000_0005);
    tick();
    chk("x0_pending", dut.u_sb.pending, 32'h0000_0200);
    chk("x0_hz1", 32'(hz1_o), 32'd0);
    a2_i = 5'd9;
    #1 chk("hz2_rd9", 32'(hz2_o), 32'd1);

    // Async reset while in WAIT with pending[3] set.
    a_we_i = 1'b0; issue_rd_i = 5'd3;
    tick();
    issue_valid_i = 1'b0;
    a_we_i = 1'b1; a_rd_i = 5'd2; b_valid_i = 1'b1; b_rd_i = 5'd5;
    tick();
    chk("pre_rst_state", 32'(dut.state_r), 32'(WAIT));
    chk("pre_rst_pending", dut.u_sb.pending, 32'h0000_0208);
    #2 rst_n_i = 1'b0;
    #1;
    chk("arst_state", 32'(dut.state_r), 32'(IDLE));
    chk("arst_cnt", 32'(dut.cnt_r), 32'd0);
    chk("arst_pending", dut.u_sb.pending, 32'd0);
    chk("arst_stall", 32'(stall_o), 32'd0);
    chk("arst_hz2", 32'(hz2_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
